// File: rtl/ysyx_25030085_pc_pkg.sv
// Shared types and constants for the fetch/execute PC sequencer.
package ysyx_25030085_pc_pkg;

  typedef enum logic [2:0] {
    RESET_S,
    REQ,
    WAIT,
    EXEC,
    HALT,
    FAULT
  } state_e;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;
  localparam logic [1:0] JMP_ILL  = 2'b11;

  localparam logic [1:0] TR_CALL = 2'b01;
  localparam logic [1:0] TR_RET  = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  localparam logic [4:0] RA   = 5'd1;
  localparam logic [4:0] ZERO = 5'd0;

endpackage

// File: rtl/ysyx_25030085_npc_gen.sv
// Next-PC selection, alignment check and call/return classification.
module ysyx_25030085_npc_gen
  import ysyx_25030085_pc_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [1:0]  jump_i,
  input  logic        branch_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] npc_o,
  output logic        misaligned_o,
  output logic        is_call_o,
  output logic        is_ret_o
);

  // Jumps outrank a taken branch.
  always_comb begin
    npc_o = pc_i + 32'd4;
    if (jump_i == JMP_JAL)       npc_o = pc_i + imm_i;
    else if (jump_i == JMP_JALR) npc_o = alu_result_i & ~32'd1;
    else if (branch_i)           npc_o = alu_result_i;
  end

  assign misaligned_o = (npc_o[1:0] != 2'b00);
  assign is_call_o    = (rd_i == RA) && ((jump_i == JMP_JAL) || (jump_i == JMP_JALR));
  assign is_ret_o     = (jump_i == JMP_JALR) && (rd_i == ZERO) && (rs1_i == RA);

endmodule

// File: rtl/ysyx_25030085_pc_seq.sv
// Multi-cycle fetch/execute sequencer owning the architectural PC and emitting ftrace events.
module ysyx_25030085_pc_seq
  import ysyx_25030085_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_ready,
  input  logic [31:0] ifu_rsp_inst,
  input  logic        ifu_rsp_err,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        exu_valid,
  input  logic        exu_done,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        halt_req,
  output logic        halted,
  output logic        trap,
  output logic        trace_valid,
  output logic [1:0]  trace_kind,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_dnpc
);

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        exu_valid_q, exu_valid_d;
  logic        trace_valid_q, trace_valid_d;
  logic [1:0]  trace_kind_q, trace_kind_d;
  logic [31:0] trace_pc_q, trace_pc_d, trace_dnpc_q, trace_dnpc_d;

  logic [31:0] npc;
  logic        misaligned, is_call, is_ret;

  ysyx_25030085_npc_gen u_npc_gen (
    .pc_i         (pc_q),
    .rd_i         (inst_q[11:7]),
    .rs1_i        (inst_q[19:15]),
    .jump_i       (jump),
    .branch_i     (branch),
    .imm_i        (imm),
    .alu_result_i (alu_result),
    .npc_o        (npc),
    .misaligned_o (misaligned),
    .is_call_o    (is_call),
    .is_ret_o     (is_ret)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RESET_S;
      pc_q          <= RESET_PC;
      inst_q        <= '0;
      tmo_q         <= '0;
      exu_valid_q   <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_kind_q  <= '0;
      trace_pc_q    <= '0;
      trace_dnpc_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      tmo_q         <= tmo_d;
      exu_valid_q   <= exu_valid_d;
      trace_valid_q <= trace_valid_d;
      trace_kind_q  <= trace_kind_d;
      trace_pc_q    <= trace_pc_d;
      trace_dnpc_q  <= trace_dnpc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    tmo_d         = tmo_q;
    exu_valid_d   = 1'b0;
    trace_valid_d = 1'b0;
    trace_kind_d  = trace_kind_q;
    trace_pc_d    = trace_pc_q;
    trace_dnpc_d  = trace_dnpc_q;
    case (state_q)
      RESET_S: state_d = REQ;
      REQ: begin
        if (ifu_req_ready) begin
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 8'd1;
        // A response arriving on the final timeout cycle is still honoured.
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = FAULT;
          end else begin
            inst_d      = ifu_rsp_inst;
            exu_valid_d = 1'b1;
            state_d     = EXEC;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
        end
      end
      EXEC: begin
        if (exu_done) begin
          if (halt_req)              state_d = HALT;
          else if (jump == JMP_ILL)  state_d = FAULT;
          else if (misaligned)       state_d = FAULT;
          else begin
            pc_d    = npc;
            state_d = REQ;
            if (is_call || is_ret) begin
              trace_valid_d = 1'b1;
              trace_kind_d  = is_call ? TR_CALL : TR_RET;
              trace_pc_d    = pc_q;
              trace_dnpc_d  = npc;
            end
          end
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = RESET_S;
    endcase
  end

  assign ifu_req_valid = (state_q == REQ);
  assign ifu_req_addr  = pc_q;
  assign ifu_rsp_ready = (state_q == WAIT);
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign exu_valid     = exu_valid_q;
  assign halted        = (state_q == HALT);
  assign trap          = (state_q == FAULT);
  assign trace_valid   = trace_valid_q;
  assign trace_kind    = trace_kind_q;
  assign trace_pc      = trace_pc_q;
  assign trace_dnpc    = trace_dnpc_q;

endmodule
